instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage for the multi-cycle RV32 core. Holds the program counter, issues one word-aligned read at a time to instruction memory over a valid/ready request port, and presents each returned 32-bit instruction with its PC to the decode/register-bank stage over a valid/ready output. Control redirects (branch/jump) are accepted in any state and discard stale in-flight data.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- imem_req_valid  output  1  read request pending
- imem_req_ready  input  1  memory accepts request this cycle
- imem_req_addr  output  32  byte address of request, always word-aligned
- imem_resp_valid  input  1  read data valid; exactly one per accepted request, no earlier than the cycle after acceptance
- imem_resp_data  input  32  instruction word
- redirect_valid  input  1  load new PC this cycle
- redirect_pc  input  32  target PC; bits [1:0] ignored, forced to 0
- instr_valid  output  1  instruction/instr_pc valid for decode
- instr_ready  input  1  decode consumes instruction this cycle
- instruction  output  32  fetched instruction word
- instr_pc  output  32  address instruction was fetched from

## Operation
- Registers: pc (next fetch address), state, instruction, instr_pc, instr_valid.
- States: REQ, WAIT, HOLD, DRAIN. All outputs registered or decoded from state only.
- Reset: pc=RESET_PC, state=REQ, instr_valid=0, instruction=0, instr_pc=0. imem_req_valid=0 during the reset cycle, 1 on the first cycle after.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready -> WAIT.
- WAIT: on imem_resp_valid: instruction<=imem_resp_data, instr_pc<=pc, instr_valid<=1, pc<=pc+4, -> HOLD.
- HOLD: instr_valid=1, instruction/instr_pc stable. On instr_ready: instr_valid<=0, -> REQ.
- DRAIN: waiting for the response to an abandoned request; imem_req_valid=0. On imem_resp_valid: data discarded, -> REQ.
- imem_req_valid, once high, stays high with stable address until accepted, except under redirect.
- Redirect (priority over all other events): pc<=redirect_pc & ~3, instr_valid<=0. Next state:
  - REQ without acceptance same cycle -> REQ (new address next cycle).
  - REQ with acceptance same cycle -> DRAIN.
  - WAIT without response -> DRAIN.
  - WAIT with response same cycle -> REQ, response discarded, pc not incremented.
  - HOLD (with or without instr_ready) -> REQ, held instruction dropped.
  - DRAIN -> DRAIN, or REQ if response arrives same cycle.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Reset mid-operation: any outstanding memory response after reset is not tracked; memory is required to be reset in the same cycle.

## Timing
- Request accepted cycle N -> earliest response N+1 -> instr_valid high N+2.
- Output handshake cycle M -> instr_valid low M+1, imem_req_valid high M+1.
- Zero-wait memory, always-ready decode: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect cycle R -> imem_req_valid with new address at R+1 (from REQ/HOLD/WAIT+resp) or one cycle after drained response.
- At most one request outstanding at all times.

## Test plan
- Reset with RESET_PC=32'h0000_0100, zero-wait memory, instr_ready=1 -> requests 0x100, 0x104, 0x108; instr_pc matches; instr_valid pulses every 3 cycles.
- Memory response delayed 4 cycles and instr_ready low 5 cycles -> request address and instruction/instr_pc stable throughout; no second request issued.
- Redirect to 32'h0000_2003 while in WAIT; response 32'hDEAD_BEEF arrives 2 cycles later -> DEAD_BEEF never appears on instr_valid; next request address 0x2000.
- Redirect in same cycle as request acceptance, and separately same cycle as response -> DRAIN then REQ 0x2000, resp ignored / direct REQ 0x2000 respectively; pc not incremented.
- Redirect to 32'hFFFF_FFFC, fetch two instructions -> instr_pc sequence 0xFFFF_FFFC, 0x0000_0000.
- Assert rst during HOLD with instr_valid=1 -> next cycle instr_valid=0, instruction=0, pc=RESET_PC, request reissued from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's buses: the instruction-memory request/response port,
// the control redirect input and the valid/ready instruction output to decode.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instruction,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instruction,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage of the multi-cycle RV32 core: one outstanding word read at a time,
// each returned instruction is held for decode until consumed; redirects drop stale data.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    instruction_fetch_if.master bus
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instruction_q, instruction_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= REQ;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            instruction_q <= 32'h0;
            instr_pc_q    <= 32'h0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instruction_q <= instruction_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instruction_d = instruction_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            REQ: begin
                if (bus.imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_resp_valid) begin
                    instruction_d = bus.imem_resp_data;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 32'd4;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            DRAIN: begin
                if (bus.imem_resp_valid) begin
                    state_d = REQ;
                end
            end
        endcase

        // A redirect wins over everything; an in-flight request must still be drained
        // so the memory never sees a second request before its pending response.
        if (bus.redirect_valid) begin
            pc_d          = {bus.redirect_pc[31:2], 2'b00};
            instr_valid_d = 1'b0;
            instruction_d = instruction_q;
            instr_pc_d    = instr_pc_q;
            case (state_q)
                REQ:     state_d = bus.imem_req_ready ? DRAIN : REQ;
                WAIT:    state_d = bus.imem_resp_valid ? REQ : DRAIN;
                HOLD:    state_d = REQ;
                DRAIN:   state_d = bus.imem_resp_valid ? REQ : DRAIN;
            endcase
        end
    end

    // Request is suppressed during the reset cycle itself so nothing is issued from a stale pc.
    assign bus.imem_req_valid = (state_q == REQ) && !rst;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = instr_valid_q;
    assign bus.instruction    = instruction_q;
    assign bus.instr_pc       = instr_pc_q;

endmodule
